uart_byte_rx: RTL and testbench



---
 rtl/uart_byte_rx.sv | 167 ++++++++++++++++
 tb/tb_uart_byte_rx.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_byte_rx.sv
// 8N1 UART byte receiver: 16x oversampling, 3-sample majority vote per bit,
// one-cycle rx_done strobe with a coincident frame_err strobe on a low stop bit.
module uart_byte_rx #(
    parameter int unsigned DIV0 = 324,
    parameter int unsigned DIV1 = 162,
    parameter int unsigned DIV2 = 80,
    parameter int unsigned DIV3 = 53,
    parameter int unsigned DIV4 = 26
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       rx,
    input  logic [2:0] baud_set,
    output logic [7:0] data_byte,
    output logic       rx_done,
    output logic       frame_err,
    output logic       uart_state
);

    typedef enum logic {
        IDLE = 1'b0,
        RECV = 1'b1
    } state_t;

    state_t     state;
    state_t     state_next;

    logic       rx_s1;
    logic       rx_s2;
    logic       rx_s3;

    logic [8:0] div_sel;
    logic [8:0] div_max;
    logic [8:0] div_cnt;
    logic [7:0] samp_cnt;
    logic [3:0] bit_idx;
    logic [3:0] phase;
    logic [1:0] vote_cnt;
    logic [1:0] vote_sum;
    logic [7:0] shift_reg;

    logic       start;
    logic       tick;
    logic       vote_bit;
    logic       sample_tick;
    logic       start_glitch;
    logic       frame_end;

    // rx_s3 only exists to give a registered previous value for edge detection.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rx_s1 <= 1'b1;
            rx_s2 <= 1'b1;
            rx_s3 <= 1'b1;
        end else begin
            rx_s1 <= rx;
            rx_s2 <= rx_s1;
            rx_s3 <= rx_s2;
        end
    end

    always_comb begin
        div_sel = 9'(DIV0);
        case (baud_set)
            3'd1:    div_sel = 9'(DIV1);
            3'd2:    div_sel = 9'(DIV2);
            3'd3:    div_sel = 9'(DIV3);
            3'd4:    div_sel = 9'(DIV4);
            default: div_sel = 9'(DIV0);
        endcase
    end

    assign start        = (state == IDLE) && rx_s3 && !rx_s2;
    assign tick         = (state == RECV) && (div_cnt == div_max);
    assign bit_idx      = samp_cnt[7:4];
    assign phase        = samp_cnt[3:0];
    // The sample taken on this tick counts toward the vote it completes.
    assign vote_sum     = vote_cnt + {1'b0, rx_s2};
    assign vote_bit     = vote_sum[1];
    assign sample_tick  = tick && (phase >= 4'd6) && (phase <= 4'd8);
    assign start_glitch = tick && (samp_cnt == 8'd8) && vote_bit;
    assign frame_end    = tick && (samp_cnt == 8'd152);
    assign uart_state   = (state == RECV);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: begin
                if (start) begin
                    state_next = RECV;
                end
            end
            RECV: begin
                if (start_glitch || frame_end) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Divider max is captured per frame so baud_set may change freely mid-frame.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_max  <= '0;
            div_cnt  <= '0;
            samp_cnt <= '0;
        end else begin
            if (start) begin
                div_max <= div_sel;
            end

            if (start || (state != RECV) || (div_cnt == div_max)) begin
                div_cnt <= '0;
            end else begin
                div_cnt <= div_cnt + 9'd1;
            end

            if (start) begin
                samp_cnt <= '0;
            end else if (tick) begin
                samp_cnt <= samp_cnt + 8'd1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vote_cnt  <= '0;
            shift_reg <= '0;
        end else begin
            if (start || (phase == 4'd0)) begin
                vote_cnt <= '0;
            end else if (sample_tick) begin
                vote_cnt <= vote_sum;
            end

            if (tick && (phase == 4'd8) && (bit_idx >= 4'd1) && (bit_idx <= 4'd8)) begin
                shift_reg <= {vote_bit, shift_reg[7:1]};
            end
        end
    end

    // Byte is delivered even with a bad stop bit; frame_err lets the consumer decide.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            data_byte <= '0;
            rx_done   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            rx_done   <= frame_end;
            frame_err <= frame_end && !vote_bit;
            if (frame_end) begin
                data_byte <= shift_reg;
            end
        end
    end

endmodule

// File: tb/tb_uart_byte_rx.sv
// Directed and randomized bench for uart_byte_rx: serial frames are driven bit by
// bit and received bytes are checked against a queue of expected bytes/flags.
module tb_uart_byte_rx;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       rx = 1'b1;
    logic [2:0] baud_set = 3'd4;
    logic [7:0] data_byte;
    logic       rx_done;
    logic       frame_err;
    logic       uart_state;

    int errors = 0;
    int checks = 0;
    int stray_err = 0;
    int busy;
    int busy_sum;
    logic [7:0] rnd;
    logic [8:0] got_q[$];
    logic [8:0] exp_q[$];

    always #10 clk = ~clk;

    uart_byte_rx dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .rx         (rx),
        .baud_set   (baud_set),
        .data_byte  (data_byte),
        .rx_done    (rx_done),
        .frame_err  (frame_err),
        .uart_state (uart_state)
    );

    always @(negedge clk) begin
        if (rx_done) begin
            got_q.push_back({frame_err, data_byte});
        end else if (frame_err) begin
            stray_err++;
        end
    end

    // Clocks per oversample tick for each baud_set value.
    function automatic int tick_clk(input logic [2:0] b);
        case (b)
            3'd1:    return 163;
            3'd2:    return 81;
            3'd3:    return 54;
            3'd4:    return 27;
            default: return 325;
        endcase
    endfunction

    task automatic check_output(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    // Drives one 8N1 frame cycle by cycle; optional glitch, abort and baud change points.
    task automatic apply_stimulus(input logic [7:0] data, input logic stop_bit, input int glitch_at,
                                  input int abort_at, input int baud_change_at, input logic [2:0] new_baud,
                                  output int busy_cycles);
        int bit_clk;
        int limit;
        logic [9:0] frame;
        bit_clk = 16 * tick_clk(baud_set);
        frame = {stop_bit, data, 1'b0};
        limit = (abort_at >= 0) ? abort_at : 10 * bit_clk;
        busy_cycles = 0;
        for (int c = 0; c < limit; c++) begin
            @(posedge clk);
            #1;
            rx = frame[c / bit_clk] ^ (c == glitch_at);
            if (c == baud_change_at) baud_set = new_baud;
            @(negedge clk);
            if (uart_state) busy_cycles++;
        end
    endtask

    task automatic drive_line(input int low_clk, input int window, output int busy_cycles);
        busy_cycles = 0;
        for (int c = 0; c < window; c++) begin
            @(posedge clk);
            #1;
            rx = (c < low_clk) ? 1'b0 : 1'b1;
            @(negedge clk);
            if (uart_state) busy_cycles++;
        end
    endtask

    task automatic drain(input string tag);
        check_output({tag, " count"}, got_q.size(), exp_q.size());
        while (got_q.size() > 0 && exp_q.size() > 0) begin
            logic [8:0] g;
            logic [8:0] e;
            g = got_q.pop_front();
            e = exp_q.pop_front();
            check_output({tag, " byte"}, {24'd0, g[7:0]}, {24'd0, e[7:0]});
            check_output({tag, " frame_err"}, {31'd0, g[8]}, {31'd0, e[8]});
        end
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_reset_outputs(input string tag);
        check_output({tag, " data_byte"}, {24'd0, data_byte}, 32'd0);
        check_output({tag, " rx_done"}, {31'd0, rx_done}, 32'd0);
        check_output({tag, " frame_err"}, {31'd0, frame_err}, 32'd0);
        check_output({tag, " uart_state"}, {31'd0, uart_state}, 32'd0);
    endtask

    initial begin
        $display("[TB] start");
        repeat (5) @(posedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        #1 rst_n = 1'b1;
        drive_line(0, 20, busy);

        baud_set = 3'd4;
        apply_stimulus(8'hA5, 1'b1, -1, -1, -1, 3'd0, busy);
        exp_q.push_back({1'b0, 8'hA5});
        check_output("a5 busy", busy, 153 * 27);
        drain("a5");
        check_output("a5 data_byte", {24'd0, data_byte}, 32'hA5);

        baud_set = 3'd3;
        drive_line(0, 10, busy);
        apply_stimulus(8'h3C, 1'b1, -1, -1, -1, 3'd0, busy);
        exp_q.push_back({1'b0, 8'h3C});
        check_output("3c baud3 busy", busy, 153 * 54);
        drain("3c baud3");

        // Runt start pulses measure each divider without full-length frames.
        for (int b = 0; b < 8; b++) begin
            if (b == 3 || b == 4) continue;
            baud_set = 3'(b);
            drive_line(5 * tick_clk(3'(b)), 12 * tick_clk(3'(b)), busy);
            check_output($sformatf("runt baud%0d busy", b), busy, 9 * tick_clk(3'(b)));
            drain($sformatf("runt baud%0d", b));
            check_output($sformatf("runt baud%0d data_byte", b), {24'd0, data_byte}, 32'h3C);
        end

        baud_set = 3'd4;
        busy_sum = 0;
        apply_stimulus(8'h00, 1'b1, -1, -1, -1, 3'd0, busy);
        busy_sum += busy;
        apply_stimulus(8'hFF, 1'b1, -1, -1, -1, 3'd0, busy);
        busy_sum += busy;
        apply_stimulus(8'h55, 1'b1, -1, -1, -1, 3'd0, busy);
        busy_sum += busy;
        exp_q.push_back({1'b0, 8'h00});
        exp_q.push_back({1'b0, 8'hFF});
        exp_q.push_back({1'b0, 8'h55});
        check_output("b2b busy", busy_sum, 3 * 153 * 27);
        drain("b2b");

        drive_line(135, 400, busy);
        check_output("runt135 busy", busy, 9 * 27);
        check_output("runt135 uart_state", {31'd0, uart_state}, 32'd0);
        check_output("runt135 data_byte", {24'd0, data_byte}, 32'h55);
        drain("runt135");

        apply_stimulus(8'h81, 1'b0, -1, -1, -1, 3'd0, busy);
        exp_q.push_back({1'b1, 8'h81});
        drive_line(0, 50, busy);
        drain("stop low");

        apply_stimulus(8'h00, 1'b1, 1512, -1, -1, 3'd0, busy);
        exp_q.push_back({1'b0, 8'h00});
        drain("glitch");

        apply_stimulus(8'h00, 1'b0, -1, -1, -1, 3'd0, busy);
        exp_q.push_back({1'b1, 8'h00});
        drive_line(864, 864, busy);
        check_output("held low no restart", busy, 0);
        drive_line(0, 30, busy);
        drain("held low");

        for (int i = 0; i < 2; i++) begin
            rnd = 8'($urandom_range(255, 1));
            apply_stimulus(rnd, 1'b1, -1, -1, -1, 3'd0, busy);
            exp_q.push_back({1'b0, rnd});
            drain($sformatf("random%0d", i));
        end

        rnd = 8'($urandom_range(255, 1));
        apply_stimulus(rnd, 1'b1, -1, -1, 1000, 3'd0, busy);
        baud_set = 3'd4;
        exp_q.push_back({1'b0, rnd});
        check_output("baud change busy", busy, 153 * 27);
        drain("baud change");

        apply_stimulus(8'hC3, 1'b1, -1, 5 * 432 + 200, -1, 3'd0, busy);
        rst_n = 1'b0;
        rx = 1'b1;
        @(negedge clk);
        check_reset_outputs("abort");
        repeat (10) @(posedge clk);
        #1 rst_n = 1'b1;
        drive_line(0, 50, busy);
        drain("abort");

        apply_stimulus(8'h5A, 1'b1, -1, -1, -1, 3'd0, busy);
        exp_q.push_back({1'b0, 8'h5A});
        drain("after abort");
        check_output("after abort data_byte", {24'd0, data_byte}, 32'h5A);

        check_output("stray frame_err", stray_err, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
